md5_msg_padder: RTL and testbench

MD5_MSG_PADDER -- requirements
Module: md5_msg_padder

---
 rtl/md5_pkg.sv | 27 ++
 rtl/md5_block_buffer.sv | 63 ++++++
 rtl/md5_msg_padder.sv | 166 ++++++++++++++++
 tb/tb_md5_msg_padder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// ---------------------------------------------------------------------------
// md5_pkg
// Shared constants and types for the MD5 message padder.
//   MD5_BLOCK_BYTES : bytes per 512-bit MD5 block
//   MD5_LEN_OFFSET  : first byte of the 64-bit little-endian bit length
//   MD5_PAD_BYTE    : the mandatory '1' bit followed by zeros
//   pad_state_t     : padder FSM states
//   len_fits()      : true when a block holding n bytes plus the pad byte
//                     still has room for the length field
// ---------------------------------------------------------------------------
package md5_pkg;

  localparam int          MD5_BLOCK_BYTES = 64;
  localparam int          MD5_LEN_OFFSET  = 56;
  localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_OUT       = 2'd1,
    ST_OUT_EXTRA = 2'd2
  } pad_state_t;

  function automatic logic len_fits(input logic [6:0] n);
    return n < 7'(MD5_LEN_OFFSET);
  endfunction

endpackage

// File: rtl/md5_block_buffer.sv
// ---------------------------------------------------------------------------
// md5_block_buffer
// 64-byte block register with byte writes, padding and length insertion.
// Byte k of the block lives at bits [8k+7:8k].
// Ports:
//   clk, reset        : clock, asynchronous active-high reset (clears block)
//   wr_en/wr_ptr/wr_data : write one message byte at byte position wr_ptr
//   pad_en            : finalize the block; bytes below pad_n are kept
//                       (including a same-cycle write), 0x80 goes at pad_n,
//                       everything above is zeroed
//   pad_n             : number of message bytes in the block (0..64)
//   pad_len_en        : also place len at bytes 56..63 while padding
//   extra_en          : replace the block with a trailer block (zeros + len)
//   extra_pad         : trailer block also carries 0x80 at byte 0
//   len               : 64-bit message bit length, little-endian
//   block             : registered 512-bit block
// ---------------------------------------------------------------------------
module md5_block_buffer
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [5:0]   wr_ptr,
  input  logic [7:0]   wr_data,
  input  logic         pad_en,
  input  logic [6:0]   pad_n,
  input  logic         pad_len_en,
  input  logic         extra_en,
  input  logic         extra_pad,
  input  logic [63:0]  len,
  output logic [511:0] block
);

  logic [511:0] base;
  logic [511:0] nxt;

  always_comb begin
    base = block;
    if (wr_en) base[{wr_ptr, 3'b000} +: 8] = wr_data;
    nxt = base;
    if (pad_en) begin
      // Stale bytes from an earlier message above pad_n are scrubbed here,
      // so the buffer never needs an explicit clear between messages.
      for (int k = 0; k < MD5_BLOCK_BYTES; k++) begin
        if (7'(k) == pad_n)     nxt[k*8 +: 8] = MD5_PAD_BYTE;
        else if (7'(k) > pad_n) nxt[k*8 +: 8] = 8'h00;
      end
      if (pad_len_en) nxt[MD5_LEN_OFFSET*8 +: 64] = len;
    end
    if (extra_en) begin
      nxt = '0;
      if (extra_pad) nxt[7:0] = MD5_PAD_BYTE;
      nxt[MD5_LEN_OFFSET*8 +: 64] = len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) block <= '0;
    else       block <= nxt;
  end

endmodule

// File: rtl/md5_msg_padder.sv
// ---------------------------------------------------------------------------
// md5_msg_padder
// Accepts a byte stream and emits MD5-padded 512-bit blocks.
// Ports:
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready/in_data : byte input handshake
//   in_last      : final byte of the message
//   in_nodata    : with in_last, the beat carries no byte
//   in_abort     : (only with MD5_PAD_ABORT_EN) drop the partial message
//   out_valid/out_ready/out_block : block output handshake
//   out_first    : block is the first of its message
//   out_last     : block is the final block of its message
// Parameter:
//   LEN_W        : width of the bit-length field; upper bits emitted as zero
// Build option:
//   MD5_PAD_ABORT_EN adds the in_abort input.
// ---------------------------------------------------------------------------
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_nodata,
`ifdef MD5_PAD_ABORT_EN
  input  logic         in_abort,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         out_first,
  output logic         out_last
);

  localparam logic [63:0] LEN_MASK =
    (LEN_W >= 64) ? {64{1'b1}} : ((64'd1 << LEN_W) - 64'd1);

  pad_state_t  state;
  logic [5:0]  ptr;
  logic [63:0] cnt;
  logic        extra_pend;
  logic        extra_pad;

  logic        abort;
  logic        take;
  logic        has_byte;
  logic [6:0]  n;
  logic [63:0] cnt_inc;
  logic        pad_en;
  logic        extra_en;
  logic [63:0] len;

`ifdef MD5_PAD_ABORT_EN
  assign abort = in_abort && (state == ST_FILL);
`else
  assign abort = 1'b0;
`endif

  function automatic logic [63:0] bit_len(input logic [63:0] c);
    return (c << 3) & LEN_MASK;
  endfunction

  assign in_ready = (state == ST_FILL);
  assign take     = in_valid && in_ready && !abort;
  // Only a terminating nodata beat is empty; nodata alone is a normal byte.
  assign has_byte = !(in_last && in_nodata);
  assign n        = {1'b0, ptr} + 7'(has_byte);
  assign cnt_inc  = cnt + 64'(has_byte);
  assign pad_en   = take && in_last;
  assign extra_en = (state == ST_OUT) && out_ready && extra_pend;
  assign len      = pad_en ? bit_len(cnt_inc) : bit_len(cnt);

  md5_block_buffer u_buf (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (take && has_byte),
    .wr_ptr     (ptr),
    .wr_data    (in_data),
    .pad_en     (pad_en),
    .pad_n      (n),
    .pad_len_en (len_fits(n)),
    .extra_en   (extra_en),
    .extra_pad  (extra_pad),
    .len        (len),
    .block      (out_block)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FILL;
      ptr        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_first  <= 1'b1;
      out_last   <= 1'b0;
      extra_pend <= 1'b0;
      extra_pad  <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (abort) begin
            ptr       <= '0;
            cnt       <= '0;
            out_first <= 1'b1;
          end else if (in_valid) begin
            cnt <= cnt_inc;
            if (in_last) begin
              ptr       <= '0;
              state     <= ST_OUT;
              out_valid <= 1'b1;
              if (len_fits(n)) begin
                out_last   <= 1'b1;
                extra_pend <= 1'b0;
              end else begin
                out_last   <= 1'b0;
                extra_pend <= 1'b1;
                // A full data block leaves no room for the pad byte.
                extra_pad  <= (n == 7'(MD5_BLOCK_BYTES));
              end
            end else begin
              ptr <= ptr + 6'd1;
              if (ptr == 6'd63) begin
                state      <= ST_OUT;
                out_valid  <= 1'b1;
                out_last   <= 1'b0;
                extra_pend <= 1'b0;
              end
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (extra_pend) begin
              state      <= ST_OUT_EXTRA;
              out_last   <= 1'b1;
              out_first  <= 1'b0;
              extra_pend <= 1'b0;
            end else begin
              state     <= ST_FILL;
              out_valid <= 1'b0;
              out_first <= out_last;
              out_last  <= 1'b0;
              if (out_last) cnt <= '0;
            end
          end
        end
        ST_OUT_EXTRA: begin
          if (out_ready) begin
            state     <= ST_FILL;
            out_valid <= 1'b0;
            out_first <= 1'b1;
            out_last  <= 1'b0;
            cnt       <= '0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
module tb_md5_msg_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_nodata;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         out_first;
  logic         out_last;

  int errors = 0;
  int checks = 0;

  logic [511:0] exp_blk, exp_blk2, b1, b2;
  logic         f1, l1, f2, l2;

  always #5 clk = ~clk;

  md5_msg_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nodata (in_nodata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_first (out_first),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [7:0] d, input logic last, input logic nodata);
    int t = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_nodata = nodata;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nodata = 1'b0;
  endtask

  task automatic get_block(output logic [511:0] b, output logic f, output logic l);
    int t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid_wait", out_valid, 1);
    b = out_block;
    f = out_first;
    l = out_last;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_abc(input string tag, input logic nod);
    send(8'h61, 1'b0, nod);
    send(8'h62, 1'b0, 1'b0);
    send(8'h63, 1'b1, 1'b0);
    chk({tag, "_latency"}, out_valid, 1);
    chk({tag, "_in_ready_low"}, in_ready, 0);
    get_block(b1, f1, l1);
    exp_blk = '0;
    exp_blk[7:0]     = 8'h61;
    exp_blk[15:8]    = 8'h62;
    exp_blk[23:16]   = 8'h63;
    exp_blk[31:24]   = 8'h80;
    exp_blk[455:448] = 8'h18;
    chk({tag, "_block"}, b1, exp_blk);
    chk({tag, "_first"}, f1, 1);
    chk({tag, "_last"}, l1, 1);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_nodata = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_first", out_first, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_block", out_block, '0);
    reset = 1'b0;
    @(negedge clk);

    run_abc("abc", 1'b0);
    // in_nodata on a non-final beat is a normal byte
    run_abc("abc_nodata_mid", 1'b1);

    // Empty message
    send(8'h00, 1'b1, 1'b1);
    get_block(b1, f1, l1);
    exp_blk = '0;
    exp_blk[7:0] = 8'h80;
    chk("empty_block", b1, exp_blk);
    chk("empty_first", f1, 1);
    chk("empty_last", l1, 1);

    // 55 bytes: padding and length fit exactly
    for (int i = 0; i < 55; i++) send(8'h41, i == 54, 1'b0);
    get_block(b1, f1, l1);
    exp_blk = '0;
    for (int k = 0; k < 55; k++) exp_blk[k*8 +: 8] = 8'h41;
    exp_blk[447:440] = 8'h80;
    exp_blk[455:448] = 8'hB8;
    exp_blk[463:456] = 8'h01;
    chk("b55_block", b1, exp_blk);
    chk("b55_first_last", {f1, l1}, 2'b11);

    // 56 bytes: length spills into a trailer block
    for (int i = 0; i < 56; i++) send(8'h41, i == 55, 1'b0);
    get_block(b1, f1, l1);
    chk("b56_extra_latency", out_valid, 1);
    get_block(b2, f2, l2);
    exp_blk = '0;
    for (int k = 0; k < 56; k++) exp_blk[k*8 +: 8] = 8'h41;
    exp_blk[455:448] = 8'h80;
    exp_blk2 = '0;
    exp_blk2[455:448] = 8'hC0;
    exp_blk2[463:456] = 8'h01;
    chk("b56_blk1", b1, exp_blk);
    chk("b56_blk1_first_last", {f1, l1}, 2'b10);
    chk("b56_blk2", b2, exp_blk2);
    chk("b56_blk2_first_last", {f2, l2}, 2'b01);

    // 64 bytes with back-pressure on the output
    for (int i = 0; i < 64; i++) send(8'(i), i == 63, 1'b0);
    exp_blk = '0;
    for (int k = 0; k < 64; k++) exp_blk[k*8 +: 8] = 8'(k);
    for (int c = 0; c < 5; c++) begin
      chk("b64_hold_block", out_block, exp_blk);
      chk("b64_hold_ctl", {out_valid, in_ready, out_first, out_last}, 4'b1010);
      @(negedge clk);
    end
    get_block(b1, f1, l1);
    get_block(b2, f2, l2);
    exp_blk2 = '0;
    exp_blk2[7:0]     = 8'h80;
    exp_blk2[463:456] = 8'h02;
    chk("b64_blk1", b1, exp_blk);
    chk("b64_blk1_first_last", {f1, l1}, 2'b10);
    chk("b64_blk2", b2, exp_blk2);
    chk("b64_blk2_first_last", {f2, l2}, 2'b01);

    // 70 bytes: full block without in_last, then a short tail block
    fork
      begin
        for (int i = 0; i < 70; i++) send(8'(i), i == 69, 1'b0);
      end
      begin
        get_block(b1, f1, l1);
        get_block(b2, f2, l2);
      end
    join
    exp_blk2 = '0;
    for (int k = 0; k < 6; k++) exp_blk2[k*8 +: 8] = 8'(64 + k);
    exp_blk2[55:48]   = 8'h80;
    exp_blk2[455:448] = 8'h30;
    exp_blk2[463:456] = 8'h02;
    chk("b70_blk1", b1, exp_blk);
    chk("b70_blk1_first_last", {f1, l1}, 2'b10);
    chk("b70_blk2", b2, exp_blk2);
    chk("b70_blk2_first_last", {f2, l2}, 2'b01);

    // Reset in the middle of a message discards it
    for (int i = 0; i < 30; i++) send(8'h55, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    chk("midrst_out_block", out_block, '0);
    @(negedge clk);
    chk("midrst_ctl", {out_valid, in_ready, out_first}, 3'b011);
    reset = 1'b0;
    @(negedge clk);
    run_abc("abc_after_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
